// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_req_arbiter_pkg
//  Purpose  : Shared types and constants for the SRAM-like request arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_req_arbiter_pkg;

   localparam logic ARB_SRC_INST   = 1'b0;
   localparam logic ARB_SRC_DATA   = 1'b1;
   // Packed width of {wr, size, addr, wstrb, wdata}
   localparam int   ARB_REQ_BUS_WD = 71;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_INST = 2'd1,
      GRANT_DATA = 2'd2
   } grant_e;

   function automatic logic grant_src(input grant_e g);
      return (g == GRANT_DATA) ? ARB_SRC_DATA : ARB_SRC_INST;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : arb_tag_fifo
//  Purpose  : 1-bit synchronous FIFO holding the source of each in-flight request.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   localparam int              PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   logic             r_tags [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   // Guarded here too so an empty pop or full push can never corrupt the count
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_tags[r_wptr] <= push_tag;
   end

   assign head  = r_tags[r_rptr];
   assign full  = (r_count == DEPTH_CNT);
   assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_req_arbiter
//  Purpose  : Shares one SRAM-like port between inst-fetch and data masters.
//             Define ARB_RR_EN for round-robin priority (default: data first).
//  Revision : 1.0 - initial release
// ============================================================================
module sram_req_arbiter
   import sram_req_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   logic                      r_lock;
   grant_e                    r_lock_grant;
`ifdef ARB_RR_EN
   logic                      r_last_src;
`endif
   grant_e                    w_grant;
   logic                      w_granted_req;
   logic                      w_accept;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_head;
   logic [ARB_REQ_BUS_WD-1:0] w_inst_bus;
   logic [ARB_REQ_BUS_WD-1:0] w_data_bus;
   logic [ARB_REQ_BUS_WD-1:0] w_sel_bus;

   assign w_inst_bus = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
   assign w_data_bus = {data_wr, data_size, data_addr, data_wstrb, data_wdata};

   always_comb begin
      w_grant = GRANT_NONE;
      if (r_lock) begin
         w_grant = r_lock_grant;
      end else if (data_req && inst_req) begin
`ifdef ARB_RR_EN
         w_grant = (r_last_src == ARB_SRC_DATA) ? GRANT_INST : GRANT_DATA;
`else
         w_grant = GRANT_DATA;
`endif
      end else if (data_req) begin
         w_grant = GRANT_DATA;
      end else if (inst_req) begin
         w_grant = GRANT_INST;
      end
   end

   always_comb begin
      w_granted_req = 1'b0;
      w_sel_bus     = '0;
      case (w_grant)
         GRANT_INST: begin
            w_granted_req = inst_req;
            w_sel_bus     = w_inst_bus;
         end
         GRANT_DATA: begin
            w_granted_req = data_req;
            w_sel_bus     = w_data_bus;
         end
         default: begin
            w_granted_req = 1'b0;
            w_sel_bus     = '0;
         end
      endcase
   end

   assign mem_req  = w_granted_req && !w_full;
   assign w_accept = mem_req && mem_addr_ok;
   assign {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} = w_sel_bus;

   assign inst_addr_ok = w_accept && (w_grant == GRANT_INST);
   assign data_addr_ok = w_accept && (w_grant == GRANT_DATA);

   // Freeze the grant while the slave stalls so the presented request never changes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock       <= 1'b0;
         r_lock_grant <= GRANT_NONE;
      end else if (mem_req && !mem_addr_ok) begin
         r_lock       <= 1'b1;
         r_lock_grant <= w_grant;
      end else if (w_accept) begin
         r_lock       <= 1'b0;
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_src <= ARB_SRC_INST;
      end else if (w_accept) begin
         r_last_src <= grant_src(w_grant);
      end
   end
`endif

   arb_tag_fifo #(
      .DEPTH    (OUTSTANDING)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (w_accept),
      .push_tag (grant_src(w_grant)),
      .pop      (mem_data_ok),
      .head     (w_head),
      .full     (w_full),
      .empty    (w_empty)
   );

   assign inst_data_ok = mem_data_ok && !w_empty && (w_head == ARB_SRC_INST);
   assign data_data_ok = mem_data_ok && !w_empty && (w_head == ARB_SRC_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

`ifndef SYNTHESIS
   a_no_orphan_response: assert property (@(posedge clk) disable iff (reset)
      !(mem_data_ok && w_empty))
      else $warning("sram_req_arbiter: mem_data_ok with no outstanding request ignored");
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_req_arbiter
//  Purpose  : Directed bench with a queue-based reference model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

   localparam int         OUTSTANDING = 4;
   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_INST = 2'd1;
   localparam logic [1:0] G_DATA = 2'd2;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int          n_cmp = 0;
   int          n_bad = 0;

   // Reference model state
   logic [1:0]  tagq [$];
   logic        m_lock;
   logic [1:0]  m_lock_g;
   logic [1:0]  m_last;

   // Observed DUT events, consumed by the hand-computed checks
   logic [31:0] acc_code, resp_code, last_inst_rdata, last_data_rdata;
   int          n_idok, n_ddok;

   always #5 clk = ~clk;

   sram_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_wstrb   (inst_wstrb),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: recompute every output from the protocol rules each negedge
   always @(negedge clk) begin
      logic [1:0] g, head;
      logic       greq, ereq, full, do_pop;
      if (reset) begin
         tagq.delete();
         m_lock   = 1'b0;
         m_lock_g = G_NONE;
         m_last   = G_INST;
      end else begin
         full = (tagq.size() == OUTSTANDING);
         if (m_lock) g = m_lock_g;
         else if (data_req && inst_req) begin
`ifdef ARB_RR_EN
            g = (m_last == G_DATA) ? G_INST : G_DATA;
`else
            g = G_DATA;
`endif
         end
         else if (data_req) g = G_DATA;
         else if (inst_req) g = G_INST;
         else g = G_NONE;
         greq = (g == G_INST) ? inst_req : (g == G_DATA) ? data_req : 1'b0;
         ereq = greq && !full;
         chk1("mem_req", mem_req, ereq);
         if (ereq && g == G_INST) begin
            chk32("mem_addr", mem_addr, inst_addr);
            chk32("mem_wdata", mem_wdata, inst_wdata);
            chk32("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, inst_wr, inst_size, inst_wstrb});
         end else if (ereq && g == G_DATA) begin
            chk32("mem_addr", mem_addr, data_addr);
            chk32("mem_wdata", mem_wdata, data_wdata);
            chk32("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, data_wr, data_size, data_wstrb});
         end
         chk1("inst_addr_ok", inst_addr_ok, ereq && mem_addr_ok && g == G_INST);
         chk1("data_addr_ok", data_addr_ok, ereq && mem_addr_ok && g == G_DATA);
         head   = (tagq.size() > 0) ? tagq[0] : G_NONE;
         do_pop = mem_data_ok && (tagq.size() > 0);
         chk1("inst_data_ok", inst_data_ok, mem_data_ok && head == G_INST);
         chk1("data_data_ok", data_data_ok, mem_data_ok && head == G_DATA);
         if (mem_data_ok) begin
            chk32("inst_rdata", inst_rdata, mem_rdata);
            chk32("data_rdata", data_rdata, mem_rdata);
         end

         if (inst_addr_ok) acc_code = {acc_code[29:0], G_INST};
         if (data_addr_ok) acc_code = {acc_code[29:0], G_DATA};
         if (inst_data_ok) begin
            resp_code = {resp_code[29:0], G_INST};
            last_inst_rdata = inst_rdata;
            n_idok++;
         end
         if (data_data_ok) begin
            resp_code = {resp_code[29:0], G_DATA};
            last_data_rdata = data_rdata;
            n_ddok++;
         end

         if (ereq && !mem_addr_ok) begin
            m_lock   = 1'b1;
            m_lock_g = g;
         end
         if (do_pop) void'(tagq.pop_front());
         if (ereq && mem_addr_ok) begin
            m_lock = 1'b0;
            m_last = g;
            tagq.push_back(g);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek();
      @(negedge clk);
      #1;
   endtask

   task automatic set_inst(input logic rq, input logic wr, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [3:0] st, input logic [31:0] wd);
      inst_req = rq; inst_wr = wr; inst_size = sz; inst_addr = ad; inst_wstrb = st; inst_wdata = wd;
   endtask

   task automatic set_data(input logic rq, input logic wr, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [3:0] st, input logic [31:0] wd);
      data_req = rq; data_wr = wr; data_size = sz; data_addr = ad; data_wstrb = st; data_wdata = wd;
   endtask

   // One request from a single master; the source follows a fixed i%3 pattern
   task automatic issue(input int i);
      logic [31:0] v;
      v = 32'(i);
      if (i % 3 == 1) begin
         set_inst(1'b1, v[0], 2'(i % 3), 32'h8000 + v * 4, v[3:0], v * 32'h01010101);
         set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      end else begin
         set_data(1'b1, v[0], 2'(i % 3), 32'h8000 + v * 4, v[3:0], v * 32'h01010101);
         set_inst(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      end
   endtask

   // Four data reads fill the tag FIFO; the fifth must wait for a pop plus one cycle
   task automatic fill4(input string tag);
      mem_addr_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_data(1'b1, 1'b0, 2'd2, 32'h5000 + 32'(k) * 4, 4'hf, 32'h0);
         step();
      end
      set_data(1'b1, 1'b0, 2'd2, 32'h5010, 4'hf, 32'h0);
      peek();
      chk1({tag, "_full_mem_req"}, mem_req, 1'b0);
      chk1({tag, "_full_addr_ok"}, data_addr_ok, 1'b0);
      step();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h5555_0000;
      peek();
      chk1({tag, "_pop_cycle_addr_ok"}, data_addr_ok, 1'b0);
      chk1({tag, "_pop_cycle_data_ok"}, data_data_ok, 1'b1);
      step();
      mem_data_ok = 1'b0;
      peek();
      chk1({tag, "_after_pop_addr_ok"}, data_addr_ok, 1'b1);
      step();
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      mem_data_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mem_rdata = 32'h5555_0001 + 32'(k);
         step();
      end
      mem_data_ok = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1;
      set_inst(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
      acc_code = '0; resp_code = '0; last_inst_rdata = '0; last_data_rdata = '0;
      n_idok = 0; n_ddok = 0;
      repeat (3) step();
      reset = 1'b0;
      peek();
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
      chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
      chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
      chk1("rst_data_data_ok", data_data_ok, 1'b0);
      step();

      // Simultaneous requests: data first, responses routed in acceptance order
      acc_code = '0; resp_code = '0;
      set_data(1'b1, 1'b0, 2'd2, 32'h1000, 4'hf, 32'h0);
      set_inst(1'b1, 1'b0, 2'd2, 32'h2000, 4'hf, 32'h0);
      mem_addr_ok = 1'b1;
      step();
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      step();
      set_inst(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0000;
      step();
      mem_rdata = 32'hBBBB_0000;
      step();
      mem_data_ok = 1'b0;
      step();
      chk32("both_acc_order", acc_code, 32'h9);
      chk32("both_resp_order", resp_code, 32'h9);
      chk32("both_inst_rdata", last_inst_rdata, 32'hBBBB_0000);
      chk32("both_data_rdata", last_data_rdata, 32'hAAAA_0000);

      // Stalled inst request must stay on the port while data arrives
      acc_code = '0;
      mem_addr_ok = 1'b0;
      set_inst(1'b1, 1'b0, 2'd2, 32'h3000, 4'hf, 32'h0);
      step();
      set_data(1'b1, 1'b1, 2'd2, 32'h4000, 4'h3, 32'hDEAD_BEEF);
      peek();
      chk32("lock_addr_c1", mem_addr, 32'h3000);
      step();
      peek();
      chk32("lock_addr_c2", mem_addr, 32'h3000);
      step();
      mem_addr_ok = 1'b1;
      peek();
      chk1("lock_inst_accept", inst_addr_ok, 1'b1);
      step();
      set_inst(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      peek();
      chk1("lock_data_next", data_addr_ok, 1'b1);
      step();
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
      step();
      mem_rdata = 32'h2222_2222;
      step();
      mem_data_ok = 1'b0;
      step();
      chk32("lock_acc_order", acc_code, 32'h6);

      // FIFO full back-pressure
      acc_code = '0;
      fill4("full");
      chk32("full_acc_seq", acc_code, 32'h2AA);

      // Steady push+pop at count 2 across several pointer wraps
      acc_code = '0; n_idok = 0; n_ddok = 0;
      mem_addr_ok = 1'b1;
      issue(0); step();
      issue(1); step();
      mem_data_ok = 1'b1;
      for (int i = 2; i < 12; i++) begin
         issue(i);
         mem_rdata = 32'hD000_0000 + 32'(i);
         step();
      end
      mem_data_ok = 1'b0;
      issue(12); step();
      issue(13); step();
      issue(14);
      peek();
      chk1("wrap_count_full", mem_req, 1'b0);
      step();
      set_inst(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      mem_data_ok = 1'b1;
      repeat (4) step();
      mem_data_ok = 1'b0;
      step();
      chk32("wrap_inst_dok_n", n_idok, 32'd5);
      chk32("wrap_data_dok_n", n_ddok, 32'd9);

      // Orphan response with the FIFO empty is dropped; capacity is unaffected
      mem_data_ok = 1'b1; mem_rdata = 32'hEEEE_EEEE;
      peek();
      chk1("orphan_inst_dok", inst_data_ok, 1'b0);
      chk1("orphan_data_dok", data_data_ok, 1'b0);
      step();
      mem_data_ok = 1'b0;
      fill4("orphan");

      // Reset with tags outstanding, then priority under continuous contention
      set_data(1'b1, 1'b0, 2'd2, 32'h7000, 4'hf, 32'h0);
      mem_addr_ok = 1'b1;
      step(); step();
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
      peek();
      chk1("midrst_inst_dok", inst_data_ok, 1'b0);
      chk1("midrst_data_dok", data_data_ok, 1'b0);
      step();
      mem_data_ok = 1'b0;
      acc_code = '0;
      set_inst(1'b1, 1'b0, 2'd2, 32'h9000, 4'hf, 32'h0);
      set_data(1'b1, 1'b0, 2'd2, 32'hA000, 4'hf, 32'h0);
      repeat (4) step();
      set_inst(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
`ifdef ARB_RR_EN
      chk32("contend_grant_seq", acc_code, 32'h99);
`else
      chk32("contend_grant_seq", acc_code, 32'hAA);
`endif
      mem_data_ok = 1'b1;
      repeat (4) step();
      mem_data_ok = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

- Shares one SRAM-like memory port between two SRAM-like masters: the instruction-fetch channel and the data channel used by the memory stage.
- Picks one request per cycle and forwards it to the shared port.
- Records the source of every accepted request in an in-order tag FIFO, and uses it to route each `data_ok`/`rdata` back to the right master.
- Sits between the CPU core and the AXI bridge.

## Interface
Parameters:
- `OUTSTANDING`, default 4: maximum accepted-but-unanswered requests (tag FIFO depth, power of 2, ≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `inst_req`, `inst_wr` in 1 each: instruction master request / write flag.
- `inst_size` in 2, `inst_addr` in 32, `inst_wstrb` in 4, `inst_wdata` in 32: instruction master request fields.
- `inst_addr_ok` out 1: instruction request accepted this cycle.
- `inst_data_ok` out 1: instruction response this cycle.
- `inst_rdata` out 32: instruction response data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: same as the `inst_*` ports, for the data master.
- `mem_req`, `mem_wr` out 1 each: shared-port request / write flag.
- `mem_size` out 2, `mem_addr` out 32, `mem_wstrb` out 4, `mem_wdata` out 32: shared-port request fields.
- `mem_addr_ok` in 1: shared port accepted the request.
- `mem_data_ok` in 1: shared-port response valid.
- `mem_rdata` in 32: shared-port response data.

## Operation
**Protocol**
- All ports use the SRAM-like protocol:
  - A request is accepted on a cycle where `req && addr_ok`.
  - A master holds `req` and all request fields stable until accepted.
  - The slave answers in acceptance order with one `data_ok` per request; writes also receive `data_ok`.

**Grant**
- Grant is `none`, `INST` or `DATA`.
- When unlocked, data has fixed priority over inst.

**Lock**
- Set when `mem_req && !mem_addr_ok`.
- Holds the current grant until `mem_addr_ok`, so the slave never sees a request withdrawn or switched mid-wait.
- Cleared on acceptance.

**Request path**
- `mem_*` fields are muxed combinationally from the granted master.
- `mem_req = granted_req && !fifo_full`.
- Granted master's `addr_ok = mem_addr_ok && mem_req`; the other master's `addr_ok` = 0.

**Tag FIFO**
- Push the source ID on every `mem_req && mem_addr_ok`.
- Pop on every `mem_data_ok`.
- Occupancy counter is `$clog2(OUTSTANDING)+1` bits.

**Response path**
- `inst_data_ok = mem_data_ok && head==INST`.
- `data_data_ok = mem_data_ok && head==DATA`.
- `inst_rdata` and `data_rdata` both carry `mem_rdata` (broadcast).

**Boundary conditions**
- FIFO full: `mem_req`=0 and both `addr_ok`=0 until a pop. A pop and a wanted push in the same cycle are not combined; the push waits one cycle.
- Push and pop in the same cycle (not full): count unchanged, both pointers advance.
- `mem_data_ok` with the FIFO empty: ignored, no master `data_ok`, counter stays 0. Flagged by a simulation-only assertion.
- Pointers wrap modulo `OUTSTANDING`.
- Flushes in the core do not affect the arbiter. Cancelled requests still complete and are routed normally; discarding them is the master's job.

## Timing
- Request path is combinational: zero-cycle latency from master `req` to `mem_req`.
- Response path is combinational: zero-cycle latency from `mem_data_ok` to master `data_ok`.
- Registered state: lock, locked grant, FIFO storage, read/write pointers, counter.
- Values after `reset`:
  - FIFO empty, pointers 0, lock 0.
  - `mem_req` = 0 and both `addr_ok` = 0 until a master asserts `req`.
  - Both `data_ok` = 0.
- Reset mid-operation discards all outstanding tags. The slave is reset on the same edge.

## Configuration
- Macro `ARB_RR_EN`.
  - Defined: round-robin priority. A `last_grant` register, reset to INST, updates on each acceptance. When both masters request while unlocked, grant goes to the master not in `last_grant`.
  - Undefined: fixed data-over-inst priority. No `last_grant` register.

## Structure
- Add to `mycpu.h`:
  - `` `ARB_SRC_INST`` (1'b0) and `` `ARB_SRC_DATA`` (1'b1).
  - `` `ARB_REQ_BUS_WD`` = 71, the packed width of `{wr,size,addr,wstrb,wdata}`.
- One sub-module, `arb_tag_fifo`: a 1-bit-wide synchronous FIFO of depth `OUTSTANDING` with push, pop, head, full and empty.

## Test plan
- Data read `0x1000` and inst read `0x2000` asserted together, `mem_addr_ok`=1 → data accepted first, inst next cycle. `mem_data_ok` twice with `rdata` `0xAAAA0000` then `0xBBBB0000` → `data_data_ok` fires first, `inst_data_ok` fires second with `0xBBBB0000`.
- Inst request with `mem_addr_ok`=0 for 3 cycles while a data request arrives on cycle 1 → `mem_addr` stays on the inst address until accepted; data is accepted the cycle after.
- 4 data reads with no responses (`OUTSTANDING`=4) → 5th request gets `mem_req`=0 and `addr_ok`=0. After one `mem_data_ok`, the 5th is accepted the following cycle.
- Push and pop in the same cycle with count 2 → count stays 2, routing order preserved across pointer wrap (at least 10 transactions).
- `mem_data_ok` pulse with the FIFO empty → both master `data_ok` = 0, counter stays 0.
- With `ARB_RR_EN`: both masters request continuously → grants alternate DATA, INST, DATA, INST. Without it → DATA wins every cycle.
